// File: rtl/dual_fetch_queue.sv
// Dual-issue instruction fetch front end: owns the fetch PC, requests
// instruction pairs from a 1-cycle-latency memory, buffers them with their
// PCs in a circular queue and presents up to two in-order entries to decode.
module dual_fetch_queue #(
  parameter int PC_W     = 6,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_rdata0,
  input  logic [INSTR_W-1:0] im_rdata1,
  output logic               out0_valid,
  output logic [INSTR_W-1:0] out0_instr,
  output logic [PC_W-1:0]    out0_pc,
  output logic               out1_valid,
  output logic [INSTR_W-1:0] out1_instr,
  output logic [PC_W-1:0]    out1_pc,
  input  logic [1:0]         deq_count,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_PC);
  localparam logic [AW+1:0]   DEPTH_W = (AW+2)'(DEPTH);

  // Control state
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] pend_addr_q, pend_addr_d;
  logic            pending_q, pending_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;

  // Queue storage (contents are don't-care after reset)
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];

  logic [AW+1:0] used;
  logic          space_ok;
  logic [AW:0]   deq_ext, deq_eff;
  logic          push;
  logic [AW-1:0] head_p1, tail_p1;
  logic [PC_W-1:0] pend_addr_p1;

  assign head_p1      = head_q + AW'(1);
  assign tail_p1      = tail_q + AW'(1);
  assign pend_addr_p1 = pend_addr_q + PC_W'(1);

  // Slots already claimed: queued entries plus the pair still in flight.
  // The space check deliberately ignores this cycle's dequeue.
  assign used     = {1'b0, count_q} + (AW+2)'({pending_q, 1'b0});
  assign space_ok = (used + (AW+2)'(2)) <= DEPTH_W;

  assign im_req  = fetch_en & ~redirect & ~reset & space_ok;
  assign im_addr = fetch_pc_q;

  // Outputs come straight from queue registers; nothing bypasses from memory.
  assign out0_valid = (count_q >= (AW+1)'(1));
  assign out1_valid = (count_q >= (AW+1)'(2));
  assign out0_instr = instr_q[head_q];
  assign out0_pc    = pc_q[head_q];
  assign out1_instr = instr_q[head_p1];
  assign out1_pc    = pc_q[head_p1];
  assign occupancy  = count_q;

  // Next-state: clamp dequeue to what is present, push the returning pair,
  // and let a redirect override everything.
  always_comb begin
    deq_ext     = (AW+1)'(deq_count);
    deq_eff     = (deq_ext > count_q) ? count_q : deq_ext;
    push        = pending_q & ~redirect;
    count_d     = count_q + (AW+1)'({push, 1'b0}) - deq_eff;
    head_d      = head_q + deq_eff[AW-1:0];
    tail_d      = tail_q + AW'({push, 1'b0});
    fetch_pc_d  = im_req ? fetch_pc_q + PC_W'(2) : fetch_pc_q;
    pending_d   = im_req;
    pend_addr_d = im_req ? fetch_pc_q : pend_addr_q;
    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc;
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RST_PC;
      pend_addr_q <= RST_PC;
      pending_q   <= 1'b0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // Write the returning pair at tail and tail+1.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail_q]  <= im_rdata0;
      pc_q[tail_q]     <= pend_addr_q;
      instr_q[tail_p1] <= im_rdata1;
      pc_q[tail_p1]    <= pend_addr_p1;
    end
  end

  // Sanity checks: the request throttle must prevent overflow; an oversized
  // dequeue is tolerated (clamped) but flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!push || ({1'b0, count_q} + (AW+2)'(2) <= DEPTH_W))
        else $error("dual_fetch_queue: queue overflow");
      assert (redirect || deq_ext <= count_q)
        else $warning("dual_fetch_queue: deq_count larger than occupancy, clamped");
    end
  end

endmodule

// File: doc/dual_fetch_queue.md
Name: dual_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the dual-issue pipeline.
- Replaces the single-instruction "PC register + instruction memory" fetch path.
- Owns the fetch PC and requests instruction pairs (PC, PC+1) from a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned instructions with their PCs in a circular queue, presents up to two in-order instructions per cycle to decode, and flushes on a branch/jump redirect.

Parameters:
- PC_W, 6, width of the PC and instruction-memory word address.
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, >= 4.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fetch_en  in  1  allows new memory requests when 1.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  PC_W  new fetch target.
- im_req  out  1  memory request valid this cycle.
- im_addr  out  PC_W  word address of the pair's first instruction; memory also reads im_addr+1.
- im_rdata0  in  INSTR_W  instruction at the address requested the previous cycle.
- im_rdata1  in  INSTR_W  instruction at that address +1 (mod 2^PC_W).
- out0_valid  out  1  head entry valid.
- out0_instr  out  INSTR_W  head instruction.
- out0_pc  out  PC_W  head PC.
- out1_valid  out  1  second entry valid.
- out1_instr  out  INSTR_W  second instruction.
- out1_pc  out  PC_W  second PC.
- deq_count  in  2  entries consumed this cycle: 0, 1 or 2.
- occupancy  out  log2(DEPTH)+1  current queue count.

Behaviour:
- Reset (async):
  - fetch_pc = RESET_PC; count, head, tail = 0; pending = 0.
  - im_req = 0; out0_valid = out1_valid = 0; occupancy = 0.
  - im_addr = RESET_PC. Queue data contents are don't-care.
  - Reset deasserted mid-operation: fetch restarts from RESET_PC and all prior data is lost.
- Request:
  - im_req = fetch_en & ~redirect & (DEPTH - count - 2*pending >= 2).
  - The check is conservative and ignores this cycle's dequeue.
  - im_addr = fetch_pc (combinational from register).
  - On request: fetch_pc <= fetch_pc + 2 (mod 2^PC_W); pending <= 1; otherwise pending <= 0.
- Response:
  - When pending = 1 at a rising edge and there is no redirect that cycle, push im_rdata0 and im_rdata1 into the queue with PCs A and A+1 (mod 2^PC_W), where A is the address latched with the request.
  - tail advances by 2 (mod DEPTH).
  - Overflow cannot occur by construction; assertion required.
- Output:
  - out0_* is the head entry; out0_valid = (count >= 1).
  - out1_* is entry head+1 (mod DEPTH); out1_valid = (count >= 2).
  - Outputs are driven directly from queue registers; no bypass from memory to output.
- Dequeue:
  - head advances by deq_count (mod DEPTH).
  - deq_count > count is illegal: assert, and treat it as deq_count = count.
- Count update: count_next = count + 2*push - deq_eff, with push and pop in the same cycle both honoured.
- Redirect (highest priority):
  - Same edge: count, head, tail <= 0; pending <= 0; the in-flight response is discarded; fetch_pc <= redirect_pc.
  - deq_count is ignored that cycle; im_req = 0 that cycle.
  - Timing: redirect at cycle t, request at t+1, push at t+2, out0_valid = 1 from t+3.
  - Back-to-back redirects: the last one wins.
- fetch_en = 0: no new request. A pending response still lands. The queue still drains.
- PC wrap: all PC arithmetic is modulo 2^PC_W; a pair starting at 2^PC_W-1 carries PCs 63 and 0 (PC_W=6).
- Steady state (DEPTH=4, deq_count=2 every cycle): alternating request/no-request gives 1 instruction/cycle average. Full rate needs DEPTH >= 8.

Test Plan:
- Reset, then fetch_en=1, deq_count=0, memory returns 0x100+addr → im_req at cycles 0 and 1 (addr 0, 2), then stops. occupancy=4. out0=(0x100, pc 0), out1=(0x101, pc 1).
- From full (DEPTH=4), deq_count=1 for 4 cycles → out0_pc sequence 0,1,2,3. occupancy decrements to 0 with no stale out_valid. A new request fires once free space ≥ 2.
- Redirect to 0x2A while pending=1 and count=3 → next cycle occupancy=0 and the in-flight pair is dropped. im_addr=0x2A at t+1. out0_pc=0x2A, out1_pc=0x2B valid at t+3.
- Redirect_pc=63 (PC_W=6) → pushed PCs 63 and 0. The next request address is 1.
- Simultaneous push and deq_count=2 with count=2 → occupancy stays 2 and entries stay in order. deq_count=2 with count=1 → assertion fires and occupancy goes to 0.
- Assert reset mid-stream with count=3, pending=1 → all outputs clear immediately without a clock edge. After release, the first im_addr is RESET_PC.
